// File: rtl/float_div_rcp_share_arb_if.sv
// Bundle of requester, reciprocal-unit and result-stream signals for the
// shared reciprocal arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the environment around it.
interface float_div_rcp_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_data;
  logic                  rcp_sign;
  logic [7:0]            rcp_exp;
  logic [22:0]           rcp_man;
  logic [36:0]           rcp_x;
  logic                  astall;
  logic                  res_valid;
  logic                  res_ready;
  logic [36:0]           res_x;
  logic [TAG_W-1:0]      res_tag;
  logic [3:0]            inflight;

  modport slave (
    input  req_valid, req_data, rcp_x, res_ready,
    output req_ready, rcp_sign, rcp_exp, rcp_man, astall,
           res_valid, res_x, res_tag, inflight
  );

  modport master (
    output req_valid, req_data, rcp_x, res_ready,
    input  req_ready, rcp_sign, rcp_exp, rcp_man, astall,
           res_valid, res_x, res_tag, inflight
  );
endinterface

// File: rtl/float_div_rcp_share_arb.sv
// Round-robin sharing of one pipelined single-precision reciprocal unit
// between NUM_REQ requesters. A shadow valid/tag pipe runs in lock-step with
// the unit (both frozen by astall) so every result leaves tagged with the
// requester that issued it, in issue order.
module float_div_rcp_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int LAT     = 1
) (
  input logic                      aclk,
  input logic                      arst,
  float_div_rcp_share_arb_if.slave bus
);

  logic [LAT-1:0]             vld_q, vld_d;
  logic [LAT-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]           grant_idx;
  logic [NUM_REQ-1:0]         ready;
  logic [31:0]                op;
  logic                       stall;
  logic                       issue;
  logic [3:0]                 cnt;

  // Stall from the output stage, issue decision, round-robin grant, operand mux.
  // The grant scan runs twice in descending order so the last hit wins: first
  // over the wrapped-around indices below rr_ptr, then over indices at or above
  // it, giving the first valid requester at or after rr_ptr modulo NUM_REQ.
  always_comb begin
    stall     = vld_q[LAT-1] & ~bus.res_ready;
    issue     = (|bus.req_valid) & ~stall;
    grant_idx = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (TAG_W'(i) < rr_ptr_q)) grant_idx = TAG_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (TAG_W'(i) >= rr_ptr_q)) grant_idx = TAG_W'(i);
    end
    ready = '0;
    op    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && (grant_idx == TAG_W'(i))) begin
        ready[i] = 1'b1;
        op       = bus.req_data[32*i +: 32];
      end
    end
  end

  // Shadow pipe advance and pointer update; everything holds while stalled.
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (!stall) begin
      vld_d[0] = issue;
      tag_d[0] = grant_idx;
      for (int k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    if (issue) begin
      rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  // Occupancy is counted from registered valids only, so no path from req_valid.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < LAT; k++) begin
      cnt = cnt + 4'(vld_q[k]);
    end
  end

  // State registers; reset discards anything in flight and restarts at requester 0.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      vld_q    <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rcp_sign  = op[31];
  assign bus.rcp_exp   = op[30:23];
  assign bus.rcp_man   = op[22:0];
  assign bus.astall    = stall;
  assign bus.res_valid = vld_q[LAT-1];
  assign bus.res_tag   = tag_q[LAT-1];
  assign bus.res_x     = bus.rcp_x;
  assign bus.inflight  = cnt;

endmodule

// File: tb/tb_float_div_rcp_share_arb.sv
// Directed bench for the shared reciprocal arbiter. Three instances (LAT=1,2,3)
// receive the same requester/result stimulus; each has a behavioural stand-in
// for the reciprocal unit whose register chain is enabled by ~astall.
module tb_float_div_rcp_share_arb;

  localparam logic [36:0] X_ONE  = 37'h07F0000000; // 1/1.0
  localparam logic [36:0] X_1P5  = 37'h07E5555555; // 1/1.5
  localparam logic [36:0] X_QTR  = 37'h0810000000; // 1/0.25
  localparam logic [36:0] X_NEG1 = 37'h17F0000000; // 1/-1.0

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data  = '0;
  logic         res_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [36:0] xtab [4];
  logic [36:0] expq [$];
  logic [36:0] xe;
  logic [31:0] opw;
  int          slot;

  always #5 clk = ~clk;

  float_div_rcp_share_arb_if #(.NUM_REQ(4), .TAG_W(2)) b1 ();
  float_div_rcp_share_arb_if #(.NUM_REQ(4), .TAG_W(2)) b2 ();
  float_div_rcp_share_arb_if #(.NUM_REQ(4), .TAG_W(2)) b3 ();

  float_div_rcp_share_arb #(.NUM_REQ(4), .TAG_W(2), .LAT(1)) u1 (.aclk(clk), .arst(rst), .bus(b1));
  float_div_rcp_share_arb #(.NUM_REQ(4), .TAG_W(2), .LAT(2)) u2 (.aclk(clk), .arst(rst), .bus(b2));
  float_div_rcp_share_arb #(.NUM_REQ(4), .TAG_W(2), .LAT(3)) u3 (.aclk(clk), .arst(rst), .bus(b3));

  assign b1.req_valid = req_valid;
  assign b2.req_valid = req_valid;
  assign b3.req_valid = req_valid;
  assign b1.req_data  = req_data;
  assign b2.req_data  = req_data;
  assign b3.req_data  = req_data;
  assign b1.res_ready = res_ready;
  assign b2.res_ready = res_ready;
  assign b3.res_ready = res_ready;

  // Raw 37-bit reciprocal {sign, exp[7:0], frac[27:0]} of a normal float.
  function automatic logic [36:0] golden(input logic [31:0] f);
    logic [52:0] q;
    q = (53'd1 << 52) / {29'd0, 1'b1, f[22:0]};
    if (q == (53'd1 << 29)) golden = {f[31], 8'(8'd254 - f[30:23]), 28'd0};
    else                    golden = {f[31], 8'(8'd253 - f[30:23]), q[27:0]};
  endfunction

  logic [36:0] x1;
  logic [36:0] x2 [2];
  logic [36:0] x3 [3];

  always_ff @(posedge clk) begin
    if (!b1.astall) x1 <= golden({b1.rcp_sign, b1.rcp_exp, b1.rcp_man});
    if (!b2.astall) begin
      x2[0] <= golden({b2.rcp_sign, b2.rcp_exp, b2.rcp_man});
      x2[1] <= x2[0];
    end
    if (!b3.astall) begin
      x3[0] <= golden({b3.rcp_sign, b3.rcp_exp, b3.rcp_man});
      x3[1] <= x3[0];
      x3[2] <= x3[1];
    end
  end

  assign b1.rcp_x = x1;
  assign b2.rcp_x = x2[1];
  assign b3.rcp_x = x3[2];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    res_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    xtab[0] = X_ONE;
    xtab[1] = X_1P5;
    xtab[2] = X_QTR;
    xtab[3] = X_NEG1;
    req_data = {32'hBF800000, 32'h3E800000, 32'h3FC00000, 32'h3F800000};

    // Reset state, with downstream not ready
    #2;
    chk("rst_res_valid", b3.res_valid, 0);
    chk("rst_astall",    b3.astall,    0);
    chk("rst_inflight",  b3.inflight,  0);
    chk("rst_res_tag",   b3.res_tag,   0);
    chk("rst_req_ready", b1.req_ready, 0);

    // Single requester, LAT=1
    do_reset();
    req_valid = 4'b0001;
    #2;
    chk("t1_ready",    b1.req_ready, 4'b0001);
    chk("t1_operand",  {b1.rcp_sign, b1.rcp_exp, b1.rcp_man}, 32'h3F800000);
    chk("t1_inflight0", b1.inflight, 0);
    chk("t1_valid0",   b1.res_valid, 0);
    tick();
    req_valid = 4'b0000;
    #2;
    chk("t1_valid",    b1.res_valid, 1);
    chk("t1_tag",      b1.res_tag,   0);
    chk("t1_x",        b1.res_x,     X_ONE);
    chk("t1_inflight", b1.inflight,  1);
    chk("t1_idle_op",  {b1.rcp_sign, b1.rcp_exp, b1.rcp_man}, 0);
    chk("t1_idle_rdy", b1.req_ready, 0);
    tick();

    // All requesters valid, no back-pressure: 0,1,2,3,... every cycle
    do_reset();
    for (int c = 0; c < 16; c++) begin
      req_valid = 4'hF;
      #2;
      chk($sformatf("t2_rdy_c%0d", c), b1.req_ready, 64'd1 << (c % 4));
      chk($sformatf("t2_v1_c%0d", c), b1.res_valid, (c >= 1) ? 1 : 0);
      chk($sformatf("t2_v3_c%0d", c), b3.res_valid, (c >= 3) ? 1 : 0);
      if (c >= 1) begin
        chk($sformatf("t2_tag1_c%0d", c), b1.res_tag, (c - 1) % 4);
        chk($sformatf("t2_x1_c%0d", c),   b1.res_x,   xtab[(c - 1) % 4]);
      end
      if (c >= 3) begin
        chk($sformatf("t2_tag3_c%0d", c), b3.res_tag, (c - 3) % 4);
        chk($sformatf("t2_x3_c%0d", c),   b3.res_x,   xtab[(c - 3) % 4]);
      end
      tick();
    end

    // Back-pressure on LAT=3: fill, stall 5 cycles, release
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) tick();
    res_ready = 1'b0;
    for (int c = 3; c < 8; c++) begin
      #2;
      chk($sformatf("t3_astall_c%0d", c), b3.astall,    1);
      chk($sformatf("t3_rdy_c%0d", c),    b3.req_ready, 0);
      chk($sformatf("t3_tag_c%0d", c),    b3.res_tag,   0);
      chk($sformatf("t3_x_c%0d", c),      b3.res_x,     X_ONE);
      chk($sformatf("t3_inf_c%0d", c),    b3.inflight,  3);
      tick();
    end
    res_ready = 1'b1;
    for (int c = 8; c < 14; c++) begin
      #2;
      chk($sformatf("t3_astall_c%0d", c), b3.astall,    0);
      chk($sformatf("t3_valid_c%0d", c),  b3.res_valid, 1);
      chk($sformatf("t3_tag_c%0d", c),    b3.res_tag,   (c - 8) % 4);
      chk($sformatf("t3_x_c%0d", c),      b3.res_x,     xtab[(c - 8) % 4]);
      chk($sformatf("t3_rdy_c%0d", c),    b3.req_ready, 64'd1 << ((c - 5) % 4));
      tick();
    end

    // Sparse fairness on LAT=1: pointer moved to 2, then 3,1,idle,idle,3
    do_reset();
    req_valid = 4'b0010;
    #2;
    chk("t4_rdy_set", b1.req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    #2;
    chk("t4_rdy_a", b1.req_ready, 4'b1000);
    chk("t4_tag_a", b1.res_tag,   1);
    tick();
    #2;
    chk("t4_rdy_b", b1.req_ready, 4'b0010);
    chk("t4_tag_b", b1.res_tag,   3);
    tick();
    req_valid = 4'b0000;
    #2;
    chk("t4_rdy_idle0", b1.req_ready, 0);
    tick();
    #2;
    chk("t4_rdy_idle1", b1.req_ready, 0);
    chk("t4_valid_idle", b1.res_valid, 0);
    tick();
    req_valid = 4'b1010;
    #2;
    chk("t4_rdy_c", b1.req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    #2;
    chk("t4_tag_c", b1.res_tag, 3);
    chk("t4_x_c",   b1.res_x,   X_NEG1);
    tick();

    // Asynchronous reset with two ops in flight on LAT=3
    do_reset();
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    res_ready = 1'b0;
    #2;
    chk("t5_pre_astall", b3.astall,    1);
    chk("t5_pre_inf",    b3.inflight,  2);
    chk("t5_pre_valid",  b3.res_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid",  b3.res_valid, 0);
    chk("t5_rst_astall", b3.astall,    0);
    chk("t5_rst_inf",    b3.inflight,  0);
    chk("t5_rst_tag",    b3.res_tag,   0);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("t5_first_grant", b3.req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    for (int c = 1; c < 5; c++) begin
      #2;
      chk($sformatf("t5_valid_c%0d", c), b3.res_valid, (c == 3) ? 1 : 0);
      chk($sformatf("t5_inf_c%0d", c),   b3.inflight,  (c < 4) ? 1 : 0);
      if (c == 3) begin
        chk("t5_tag", b3.res_tag, 0);
        chk("t5_x",   b3.res_x,   X_ONE);
      end
      tick();
    end

    // Full LAT=2 pipe, consume and issue together, 20 random operands
    do_reset();
    for (int c = 0; c < 22; c++) begin
      for (int r = 0; r < 4; r++) begin
        opw = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 253)), 23'($urandom)};
        req_data[32*r +: 32] = opw;
      end
      slot = c % 4;
      if (c < 20) begin
        expq.push_back(golden(req_data[32*slot +: 32]));
        req_valid = 4'hF;
      end else begin
        req_valid = 4'h0;
      end
      #2;
      chk($sformatf("t6_rdy_c%0d", c), b2.req_ready, (c < 20) ? (64'd1 << slot) : 0);
      if (c >= 2) begin
        xe = expq.pop_front();
        chk($sformatf("t6_valid_c%0d", c), b2.res_valid, 1);
        chk($sformatf("t6_tag_c%0d", c),   b2.res_tag,   (c - 2) % 4);
        chk($sformatf("t6_x_c%0d", c),     b2.res_x,     xe);
        if (c < 20) chk($sformatf("t6_inf_c%0d", c), b2.inflight, 2);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/float_div_rcp_share_arb.md
Name: float_div_rcp_share_arb

Overview:
- Shares one pipelined single-precision reciprocal unit (E8/M23, 37-bit raw result `x`, stall-enabled output register) between NUM_REQ requesters.
- Arbitrates with round-robin fairness and drives the unit's operand inputs.
- Carries a requester tag alongside each operation, in lock-step with the unit's pipeline.
- Returns each result on a single tagged output stream. Downstream back-pressure is converted into the unit's `astall`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 2, tag width; must equal clog2(NUM_REQ).
- LAT, 1, enabled-clock latency of the reciprocal unit from operand to `x` (1..8).

Ports:
- aclk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_data  in  NUM_REQ*32  packed operands {sign, exp[7:0], man[22:0]}; requester i in bits [32i+31:32i].
- rcp_sign  out  1  operand sign to reciprocal unit.
- rcp_exp  out  8  operand exponent to reciprocal unit.
- rcp_man  out  23  operand mantissa to reciprocal unit.
- rcp_x  in  37  result from reciprocal unit.
- astall  out  1  stall to reciprocal unit; freezes its pipeline register(s).
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_x  out  37  result, equal to rcp_x.
- res_tag  out  TAG_W  index of the requester that issued this result.
- inflight  out  4  count of operations currently in the pipe (0..LAT).

Behaviour:
- Shadow pipe: `vld[LAT-1:0]` and `tag[LAT-1:0][TAG_W-1:0]` model the unit's stages. Stage 0 captures the issue; stage LAT-1 is the output stage.
- Stall: `astall = vld[LAT-1] & ~res_ready` (combinational). When astall=1, neither the shadow pipe nor the unit advances.
- Advance: when astall=0, `vld[0] <= issue`, `tag[0] <= grant_idx`, and `vld[k] <= vld[k-1]` (likewise tag) on every rising edge. The unit's own register moves on the same edge because its enable is ~astall.
- Issue: `issue = |req_valid & ~astall`.
  - req_ready[g]=1 only for the granted index g, only when issue=1.
  - A handshake happens when req_valid[g] & req_ready[g] are both high.
  - No requester may be granted while astall=1; all req_ready bits are 0.
- Operand mux: rcp_sign/exp/man come from req_data of the granted index when issue=1, and are 0 otherwise. Operands are combinational, with no extra register; the unit's LAT covers the timing.
- Arbitration: round-robin pointer `rr_ptr` (TAG_W bits).
  - The grant is the first asserted req_valid scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - On each issue, `rr_ptr <= (g+1) mod NUM_REQ`.
  - No issue leaves the pointer unchanged.
  - A single persistently-valid requester may be granted every cycle.
- Output: `res_valid = vld[LAT-1]`, `res_tag = tag[LAT-1]`, `res_x = rcp_x`.
  - A result is consumed when res_valid & res_ready.
  - While stalled, res_x and res_tag hold stable.
- Ordering: results leave in issue order; there is no reordering.
- Throughput is one operation per cycle with no bubbles when res_ready=1.
- inflight: population count of vld. It is registered-derived, so no combinational path from req_valid.
- Simultaneous events: when the output-stage result is consumed and a new issue happens on the same edge, inflight is unchanged (when the pipe was full).
- Reset: arst=1 immediately clears vld, tag, and rr_ptr to 0. This drives res_valid=0, astall=0, inflight=0, and res_tag=0.
  - req_ready is combinational from req_valid, so a requester granted in the reset-release cycle is legal.
  - Operations in flight at reset are discarded. No response is generated for them.
- Non-power-of-two NUM_REQ: pointer values ≥ NUM_REQ never occur; the wrap is explicit.

Test Plan:
- Single requester, LAT=1: req 0 sends 0x3F800000 (1.0) at cycle 0, res_ready=1 → res_valid at cycle 1 with res_tag=0, res_x = golden reciprocal of 1.0, inflight=1 at cycle 1.
- All 4 requesters valid continuously, res_ready=1 → grants in order 0,1,2,3,0,1..., one per cycle; res_tag sequence 0,1,2,3 delayed by LAT; zero bubbles across 16 cycles.
- Back-pressure, LAT=3: fill the pipe, drop res_ready for 5 cycles → astall=1 for exactly those 5 cycles, req_ready=0, and res_x/res_tag stable. On release, results resume in order with no loss or duplication.
- Sparse fairness: only req 1 and req 3 valid, rr_ptr=2 → grant 3 then 1 then 3; pointer is unchanged on idle cycles.
- Reset mid-operation: assert arst asynchronously with 2 ops in flight (LAT=3) → res_valid, astall, and inflight go to 0 without waiting for a clock. After release, the next grant comes from requester 0 and the discarded ops never appear.
- Simultaneous consume and issue with a full pipe (LAT=2, res_ready=1) → inflight stays 2 and the issue order is preserved over 20 random operands checked against the golden model.
